// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: blank pattern, active-low segment table
// (one source for the encoder and this reader) and the reader FSM states.
package seg7_pkg;

   // Full byte shown for a blank/dash digit (point bit set, only segment g lit).
   localparam logic [7:0] SEG_BLANK = 8'hBF;

   // Active-low segments g..a for nibble values 0..F; index 0 is the rightmost entry.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
      7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Forward mapping used by the display encoder.
   function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the segment encoder: one byte -> {num, point, nothing, err}.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg_i,
   output logic [3:0] num_o,
   output logic       point_o,
   output logic       nothing_o,
   output logic       err_o
);

   // Match the low seven bits against the shared table; the blank byte is checked whole.
   always_comb begin
      num_o     = 4'd0;
      point_o   = seg_i[7];
      nothing_o = 1'b0;
      err_o     = 1'b0;
      if (seg_i == SEG_BLANK) begin
         nothing_o = 1'b1;
      end else begin
         err_o = 1'b1;
         for (int i = 0; i < 16; i++) begin
            if (seg_i[6:0] == SEG_TABLE[i]) begin
               num_o = 4'(i);
               err_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seg7_reader.sv
// Snapshots the HEX segment bank on start, then streams each decoded digit
// over a valid/ready handshake and reports the frame's error count.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter  int NUM_DIGITS = 6,
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*NUM_DIGITS-1:0] hex_bus,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IDX_W-1:0]        out_idx,
   output logic [3:0]              out_num,
   output logic                    out_point,
   output logic                    out_nothing,
   output logic                    out_err,
   output logic                    done,
   output logic [IDX_W:0]          err_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t                  state_q;
   logic [8*NUM_DIGITS-1:0] snap_q;
   logic [IDX_W-1:0]        idx_q;
   logic [IDX_W:0]          acc_q;
   logic                    out_valid_q;
   logic [3:0]              out_num_q;
   logic                    out_point_q;
   logic                    out_nothing_q;
   logic                    out_err_q;
   logic                    done_q;
   logic [IDX_W:0]          err_count_q;

   logic [7:0]              digit_w [NUM_DIGITS];
   logic [IDX_W-1:0]        sel_idx_d;
   logic [IDX_W:0]          acc_d;
   logic [7:0]              dec_byte;
   logic [3:0]              dec_num;
   logic                    dec_point;
   logic                    dec_nothing;
   logic                    dec_err;

   // Slice the snapshot into per-digit bytes.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign digit_w[gi] = snap_q[8*gi +: 8];
      end
   endgenerate

   // The single decoder looks at the current digit in LOAD and one ahead in EMIT,
   // so the next result is ready at the handshake edge.
   always_comb begin
      sel_idx_d = idx_q;
      if ((state_q == ST_EMIT) && (idx_q != LAST_IDX)) begin
         sel_idx_d = idx_q + 1'b1;
      end
      dec_byte = digit_w[sel_idx_d];
      acc_d    = acc_q + (IDX_W+1)'(out_err_q);
   end

   seg7_decode u_decode (
      .seg_i     (dec_byte),
      .num_o     (dec_num),
      .point_o   (dec_point),
      .nothing_o (dec_nothing),
      .err_o     (dec_err)
   );

   // Frame sequencer: snapshot, per-digit emit with stall hold, one-cycle done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         snap_q        <= '0;
         idx_q         <= '0;
         acc_q         <= '0;
         out_valid_q   <= 1'b0;
         out_num_q     <= 4'd0;
         out_point_q   <= 1'b0;
         out_nothing_q <= 1'b0;
         out_err_q     <= 1'b0;
         done_q        <= 1'b0;
         err_count_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  snap_q      <= hex_bus;
                  idx_q       <= '0;
                  acc_q       <= '0;
                  err_count_q <= '0;
                  state_q     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               out_num_q     <= dec_num;
               out_point_q   <= dec_point;
               out_nothing_q <= dec_nothing;
               out_err_q     <= dec_err;
               out_valid_q   <= 1'b1;
               state_q       <= ST_EMIT;
            end
            ST_EMIT: begin
               if (out_valid_q && out_ready) begin
                  acc_q <= acc_d;
                  if (idx_q == LAST_IDX) begin
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                     err_count_q <= acc_d;
                     state_q     <= ST_FIN;
                  end else begin
                     idx_q         <= idx_q + 1'b1;
                     out_num_q     <= dec_num;
                     out_point_q   <= dec_point;
                     out_nothing_q <= dec_nothing;
                     out_err_q     <= dec_err;
                  end
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign out_valid   = out_valid_q;
   assign out_idx     = idx_q;
   assign out_num     = out_num_q;
   assign out_point   = out_point_q;
   assign out_nothing = out_nothing_q;
   assign out_err     = out_err_q;
   assign done        = done_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Randomized scoreboard bench for seg7_reader: stimulus pushes expected digits,
// a negedge monitor pops and compares on every handshake and done pulse.
module tb_seg7_reader;

   localparam int N     = 6;
   localparam int IDX_W = 3;

   logic             clk;
   logic             reset;
   logic             start;
   logic [8*N-1:0]   hex_bus;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [3:0]       out_num;
   logic             out_point;
   logic             out_nothing;
   logic             out_err;
   logic             done;
   logic [IDX_W:0]   err_count;

   seg7_reader #(.NUM_DIGITS(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hex_bus     (hex_bus),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_idx     (out_idx),
      .out_num     (out_num),
      .out_point   (out_point),
      .out_nothing (out_nothing),
      .out_err     (out_err),
      .done        (done),
      .err_count   (err_count)
   );

   typedef struct {
      int         idx;
      logic [3:0] num;
      logic       point;
      logic       nothing;
      logic       err;
   } exp_t;

   exp_t sb_q[$];
   int   exp_err_q[$];
   int   tests = 0;
   int   fails = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: 1-0-0 repeating
   int   pat_cnt = 0;
   int   dec_map[bit [6:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference mapping: the sixteen active-low codes listed for the display.
   initial begin
      dec_map[7'h40] = 0;  dec_map[7'h79] = 1;  dec_map[7'h24] = 2;  dec_map[7'h30] = 3;
      dec_map[7'h19] = 4;  dec_map[7'h12] = 5;  dec_map[7'h02] = 6;  dec_map[7'h78] = 7;
      dec_map[7'h00] = 8;  dec_map[7'h10] = 9;  dec_map[7'h08] = 10; dec_map[7'h03] = 11;
      dec_map[7'h46] = 12; dec_map[7'h21] = 13; dec_map[7'h06] = 14; dec_map[7'h0E] = 15;
   end

   function automatic exp_t model(input logic [7:0] b, input int i);
      exp_t r;
      r.idx     = i;
      r.point   = b[7];
      r.num     = 4'd0;
      r.nothing = (b == 8'hBF);
      r.err     = 1'b0;
      if (!r.nothing) begin
         if (dec_map.exists(b[6:0])) r.num = 4'(dec_map[b[6:0]]);
         else r.err = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [7:0] code_byte(input int v, input logic pt);
      foreach (dec_map[k]) if (dec_map[k] == v) return {pt, k};
      return 8'hFF;
   endfunction

   // Ready driver.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               out_ready = (pat_cnt % 3 == 0);
               pat_cnt++;
            end
         endcase
      end
   end

   // Monitor / scoreboard.
   logic        prev_stall = 1'b0;
   logic [10:0] prev_out;
   logic        expect_done = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (done || expect_done) begin
            tests++;
            if (done !== expect_done) begin
               fails++;
               $display("FAIL done_pulse: got %0b want %0b", done, expect_done);
            end else if (exp_err_q.size() == 0) begin
               fails++;
               $display("FAIL err_count: got %0d want <no frame expected>", err_count);
            end else begin
               int e;
               e = exp_err_q.pop_front();
               if (int'(err_count) != e) begin
                  fails++;
                  $display("FAIL err_count: got %0d want %0d", err_count, e);
               end
               $display("[TB] frame done err_count=%0d", err_count);
            end
         end
         expect_done = 1'b0;
         if (prev_stall) begin
            tests++;
            if ({out_valid, out_idx, out_num, out_point, out_nothing, out_err} !== prev_out) begin
               fails++;
               $display("FAIL stall_hold: got %h want %h",
                        {out_valid, out_idx, out_num, out_point, out_nothing, out_err}, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL spurious_digit: got idx=%0d want <none>", out_idx);
            end else begin
               exp_t x;
               x = sb_q.pop_front();
               if (int'(out_idx) != x.idx || out_num !== x.num || out_point !== x.point ||
                   out_nothing !== x.nothing || out_err !== x.err) begin
                  fails++;
                  $display("FAIL digit: got idx=%0d num=%h pt=%0b no=%0b err=%0b want idx=%0d num=%h pt=%0b no=%0b err=%0b",
                           out_idx, out_num, out_point, out_nothing, out_err,
                           x.idx, x.num, x.point, x.nothing, x.err);
               end else begin
                  $display("[TB] digit idx=%0d num=%h pt=%0b no=%0b err=%0b",
                           out_idx, out_num, out_point, out_nothing, out_err);
               end
               if (x.idx == N-1) expect_done = 1'b1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_valid, out_idx, out_num, out_point, out_nothing, out_err};
      end
   end

   // Called at posedge+1 with the DUT idle; scrambles hex_bus after the snapshot edge.
   task automatic launch(input logic [8*N-1:0] bus);
      int         ec;
      exp_t       x;
      logic [63:0] r;
      ec = 0;
      hex_bus = bus;
      start   = 1'b1;
      for (int i = 0; i < N; i++) begin
         x = model(bus[8*i +: 8], i);
         sb_q.push_back(x);
         if (x.err) ec++;
      end
      exp_err_q.push_back(ec);
      @(posedge clk); #1;
      start = 1'b0;
      r = {$urandom(), $urandom()};
      hex_bus = r[8*N-1:0];
   endtask

   task automatic wait_idle(input int budget, input int mid_start);
      for (int c = 0; c < budget; c++) begin
         if (!busy) begin
            start = 1'b0;
            return;
         end
         start = (mid_start != 0) && ($urandom_range(0, 2) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      tests++; fails++;
      $display("FAIL frame_timeout: got busy=%0b want 0 within %0d cycles", busy, budget);
   endtask

   task automatic run_frame(input logic [8*N-1:0] bus, input int mid_start);
      launch(bus);
      wait_idle(300, mid_start);
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 3))
         0, 1:    return code_byte($urandom_range(0, 15), 1'($urandom_range(0, 1)));
         2:       return 8'hBF;
         default: return 8'($urandom());
      endcase
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish want finish before timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [8*N-1:0] bus;
      reset   = 1'b1;
      start   = 1'b0;
      hex_bus = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({busy, out_valid, out_idx, out_num, out_point, out_nothing, out_err, done, err_count} !== '0) begin
         fails++;
         $display("FAIL reset_state: got %h want 0",
                  {busy, out_valid, out_idx, out_num, out_point, out_nothing, out_err, done, err_count});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed frame 0..5 with point bit set, ready high, latency checked.
      rdy_mode = 0;
      @(posedge clk); #1;
      bus = {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
      launch(bus);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL latency_load: got valid=%0b want 0", out_valid);
      end
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1) begin
            fails++; $display("FAIL latency_valid%0d: got valid=%0b want 1", i, out_valid);
         end
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL latency_done: got done=%0b want 1", done);
      end
      @(posedge clk); #1;
      wait_idle(50, 0);

      // All sixteen codes, point clear, across three frames.
      rdy_mode = 1;
      for (int f = 0; f < 3; f++) begin
         for (int j = 0; j < N; j++) bus[8*j +: 8] = code_byte((f*N + j) % 16, 1'b0);
         run_frame(bus, 0);
      end

      // Blank, dash without point, all-off.
      bus = {8'h7F, 8'h3F, 8'hC0, 8'hBF, 8'hC0, 8'hC0};
      run_frame(bus, 0);

      // Stall pattern 1-0-0 with mid-frame start pulses.
      rdy_mode = 2;
      for (int f = 0; f < 3; f++) begin
         for (int j = 0; j < N; j++) bus[8*j +: 8] = rand_byte();
         run_frame(bus, 1);
      end

      // Reset while emitting idx3, then a fresh frame.
      rdy_mode = 1;
      for (int j = 0; j < N; j++) bus[8*j +: 8] = rand_byte();
      launch(bus);
      begin
         int c;
         for (c = 0; c < 200; c++) begin
            if (out_valid && out_idx == 3'd3) break;
            @(posedge clk); #1;
         end
         if (c == 200) begin
            tests++; fails++;
            $display("FAIL reach_idx3: got idx=%0d want 3", out_idx);
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      sb_q.delete();
      exp_err_q.delete();
      @(negedge clk);
      tests++;
      if ({busy, out_valid, out_idx, out_num, out_point, out_nothing, out_err, done, err_count} !== '0) begin
         fails++;
         $display("FAIL midframe_reset: got %h want 0",
                  {busy, out_valid, out_idx, out_num, out_point, out_nothing, out_err, done, err_count});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) bus[8*j +: 8] = rand_byte();
      run_frame(bus, 0);

      // Random frames with random backpressure.
      for (int f = 0; f < 20; f++) begin
         rdy_mode = (f % 3 == 0) ? 0 : 1;
         for (int j = 0; j < N; j++) bus[8*j +: 8] = rand_byte();
         run_frame(bus, f % 2);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      tests++;
      if (sb_q.size() != 0 || exp_err_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d digits %0d frames left want 0 0",
                  sb_q.size(), exp_err_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
